wrr_arbiter: RTL and testbench

Four-requester weighted round-robin arbiter with burst hold, the successor to the plain round-robin arbiter in the shared-resource path. It grants one requester at a time. The grant is held for up to a per-requester weight of consecutive cycles, then rotates fairly to the next active requester. Grants are registered one-hot and change without idle bubbles when another requester is waiting.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_priority_pick.sv | 28 ++
 rtl/wrr_arbiter.sv | 103 ++++++++++
 tb/tb_wrr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Four requesters, two-bit index, one-hot grant vector.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;
    typedef logic [3:0] one_hot_t;

    function automatic one_hot_t onehot(req_idx_t idx);
        one_hot_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotated priority scan: first request at or after ptr+1, wrapping 3->0.
// The requester at ptr itself is considered last.
module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    req_idx_t cand;

    // Scan from lowest to highest priority so the best match overwrites.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + req_idx_t'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Four-requester weighted round-robin arbiter with burst hold.
// Optional burst-extend lock inputs are enabled by WRR_LOCK_EN.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int W_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req3,
    input  logic               req2,
    input  logic               req1,
    input  logic               req0,
    input  logic [W_WIDTH-1:0] weight3,
    input  logic [W_WIDTH-1:0] weight2,
    input  logic [W_WIDTH-1:0] weight1,
    input  logic [W_WIDTH-1:0] weight0,
`ifdef WRR_LOCK_EN
    input  logic               lock3,
    input  logic               lock2,
    input  logic               lock1,
    input  logic               lock0,
`endif
    output logic               gnt3,
    output logic               gnt2,
    output logic               gnt1,
    output logic               gnt0,
    output logic [1:0]         owner,
    output logic               gnt_last
);

    logic [3:0]         req;
    one_hot_t           gnt_q, gnt_d;
    logic [W_WIDTH-1:0] cnt_q, cnt_d;
    req_idx_t           ptr_q, ptr_d;
    logic [W_WIDTH-1:0] wt [NUM_REQ];
    logic [W_WIDTH-1:0] w_h, w_eff;
    logic               lock_h, expire, rearb;
    logic               win_vld;
    req_idx_t           win;

    assign req   = {req3, req2, req1, req0};
    assign wt[0] = weight0;
    assign wt[1] = weight1;
    assign wt[2] = weight2;
    assign wt[3] = weight3;

`ifdef WRR_LOCK_EN
    logic [3:0] lock;
    assign lock   = {lock3, lock2, lock1, lock0};
    assign lock_h = lock[ptr_q];
`else
    assign lock_h = 1'b0;
`endif

    // ptr always names the holder while a grant is active.
    assign w_h    = wt[ptr_q];
    assign w_eff  = (w_h == '0) ? W_WIDTH'(1) : w_h;
    assign expire = (cnt_q >= w_eff - W_WIDTH'(1)) && !lock_h;
    assign rearb  = (gnt_q == '0) || !req[ptr_q] || expire;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (win_vld),
        .idx   (win)
    );

    always_comb begin
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + W_WIDTH'(1);
        if (rearb) begin
            cnt_d = '0;
            if (win_vld) begin
                gnt_d = onehot(win);
                ptr_d = win;
            end else begin
                gnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            cnt_q <= '0;
            ptr_q <= 2'd3;
        end else begin
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt3     = gnt_q[3];
    assign gnt2     = gnt_q[2];
    assign gnt1     = gnt_q[1];
    assign gnt0     = gnt_q[0];
    assign owner    = ptr_q;
    assign gnt_last = (|gnt_q) && expire;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter; expected values are hand-derived.
// The lock scenario runs only when WRR_LOCK_EN is defined.
module tb_wrr_arbiter;

    logic       clk;
    logic       rst;
    logic       req3, req2, req1, req0;
    logic [3:0] w3, w2, w1, w0;
`ifdef WRR_LOCK_EN
    logic       lk3, lk2, lk1, lk0;
`endif
    logic       g3, g2, g1, g0;
    logic [1:0] owner;
    logic       glast;
    logic [3:0] gnt;

    int n_cmp;
    int n_bad;

    logic [3:0] rot_g [10];
    logic [1:0] rot_o [10];
    logic       rot_l [10];

    assign gnt = {g3, g2, g1, g0};

    wrr_arbiter #(.W_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req3     (req3),
        .req2     (req2),
        .req1     (req1),
        .req0     (req0),
        .weight3  (w3),
        .weight2  (w2),
        .weight1  (w1),
        .weight0  (w0),
`ifdef WRR_LOCK_EN
        .lock3    (lk3),
        .lock2    (lk2),
        .lock1    (lk1),
        .lock0    (lk0),
`endif
        .gnt3     (g3),
        .gnt2     (g2),
        .gnt1     (g1),
        .gnt0     (g0),
        .owner    (owner),
        .gnt_last (glast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        {req3, req2, req1, req0} = r;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rot_g = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h4,
                  4'h4, 4'h8, 4'h8, 4'h8, 4'h8};
        rot_o = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                  2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        rot_l = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef WRR_LOCK_EN
        {lk3, lk2, lk1, lk0} = 4'b0000;
`endif
        rst = 1'b1;
        set_req(4'b1111);
        w0 = 4'd1;
        w1 = 4'd2;
        w2 = 4'd3;
        w3 = 4'd4;

        // reset held with all requests high
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_gnt", gnt, 4'h0);
            chk("rst_owner", {2'b00, owner}, 4'd3);
            chk("rst_last", {3'b000, glast}, 4'h0);
        end

        // full rotation, two periods, no idle cycle
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("rot_gnt", gnt, rot_g[i % 10]);
            chk("rot_owner", {2'b00, owner}, {2'b00, rot_o[i % 10]});
            chk("rot_last", {3'b000, glast}, {3'b000, rot_l[i % 10]});
        end

        // sole requester re-granted, last pulse every 3rd cycle
        set_req(4'b0001);
        w0 = 4'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("solo_gnt", gnt, 4'h1);
            chk("solo_last", {3'b000, glast},
                (i % 3 == 2) ? 4'h1 : 4'h0);
        end

        // early release of req1, then weight 0 on requester 2
        set_req(4'b0110);
        w1 = 4'd4;
        w2 = 4'd0;
        step();
        chk("er_gnt1a", gnt, 4'h2);
        step();
        chk("er_gnt1b", gnt, 4'h2);
        chk("er_last1", {3'b000, glast}, 4'h0);
        set_req(4'b0101);
        step();
        chk("er_gnt2", gnt, 4'h4);
        chk("w0_last", {3'b000, glast}, 4'h1);
        step();
        chk("w0_next", gnt, 4'h1);
        chk("w0_owner", {2'b00, owner}, 4'd0);

        // mid-burst reset of a 4-cycle gnt3 burst
        w3 = 4'd4;
        set_req(4'b1000);
        step();
        chk("mr_gnt3a", gnt, 4'h8);
        step();
        chk("mr_gnt3b", gnt, 4'h8);
        rst = 1'b1;
        step();
        chk("mr_rst_gnt", gnt, 4'h0);
        chk("mr_rst_last", {3'b000, glast}, 4'h0);
        rst = 1'b0;
        set_req(4'b1001);
        step();
        chk("mr_gnt0", gnt, 4'h1);
        chk("mr_last0", {3'b000, glast}, 4'h0);

        // lowering weight mid-burst expires it immediately
        step();
        chk("wl_gnt0", gnt, 4'h1);
        chk("wl_last_pre", {3'b000, glast}, 4'h0);
        w0 = 4'd1;
        #1;
        chk("wl_last", {3'b000, glast}, 4'h1);
        step();
        chk("wl_next", gnt, 4'h8);

`ifdef WRR_LOCK_EN
        w0 = 4'd1;
        lk0 = 1'b1;
        set_req(4'b0011);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lk_gnt0", gnt, 4'h1);
            chk("lk_last", {3'b000, glast}, 4'h0);
        end
        lk0 = 1'b0;
        #1;
        chk("lk_last_drop", {3'b000, glast}, 4'h1);
        step();
        chk("lk_gnt1", gnt, 4'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
